// File: rtl/xgen_pkg.sv
// Shared definitions for the xgen sequencer and the xgen units it feeds.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default fixed-point format, xform field order, sequencer FSM state type.
package xgen_pkg;

  // Default fixed-point word: 32 bits, 16 fractional bits.
  localparam int DEF_WIDTH        = 32;
  localparam int DEF_DECIMAL_BITS = 16;

  // Number of words in one link transformation.
  localparam int XFORM_N = 15;

  // Field order of the packed xform bus. Field i occupies bits
  // [i*WIDTH +: WIDTH]. Nine angular (rotation) terms first, then the six
  // linear coupling terms.
  localparam int AX_AX = 0;
  localparam int AX_AY = 1;
  localparam int AX_AZ = 2;
  localparam int AY_AX = 3;
  localparam int AY_AY = 4;
  localparam int AY_AZ = 5;
  localparam int AZ_AX = 6;
  localparam int AZ_AY = 7;
  localparam int AZ_AZ = 8;
  localparam int LX_AX = 9;
  localparam int LX_AY = 10;
  localparam int LX_AZ = 11;
  localparam int LY_AX = 12;
  localparam int LY_AZ = 13;
  localparam int LZ_AX = 14;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/xgen_sched.sv
// Sequences sin/cos pairs per link to the xgen units and captures each link's xform.
// Latency: trig accept in c -> xgen bus c+1 -> xform_valid_out from c+2+XGEN_LAT.
// Backpressure: holds xform_out until xform_ready_in; trig_ready_out is low outside LOAD.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start_in, abort_in              begin a sweep (IDLE only) / abandon it (any other state)
//   busy_out, done_out              not IDLE / one-cycle pulse after the last link is taken
//   trig_valid_in, trig_ready_out   sin/cos handshake, sinq_in/cosq_in
//   xgen_sinq_out, xgen_cosq_out    registered broadcast to all xgen units
//   xgen_link_out                   active link (1-based, 0 = none), drives the external mux
//   xform_in                        muxed xgen output
//   xform_valid_out, xform_ready_in captured xform handshake, xform_out/xform_link_out
module xgen_sched
  import xgen_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_LINKS = 7,
  parameter int LINK_BITS = 3,   // must be able to hold NUM_LINKS
  parameter int XGEN_LAT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_in,
  input  logic                     abort_in,
  output logic                     busy_out,
  output logic                     done_out,
  input  logic                     trig_valid_in,
  output logic                     trig_ready_out,
  input  logic [WIDTH-1:0]         sinq_in,
  input  logic [WIDTH-1:0]         cosq_in,
  output logic [WIDTH-1:0]         xgen_sinq_out,
  output logic [WIDTH-1:0]         xgen_cosq_out,
  output logic [LINK_BITS-1:0]     xgen_link_out,
  input  logic [XFORM_N*WIDTH-1:0] xform_in,
  output logic                     xform_valid_out,
  input  logic                     xform_ready_in,
  output logic [LINK_BITS-1:0]     xform_link_out,
  output logic [XFORM_N*WIDTH-1:0] xform_out
);

  // Settle counter only has to reach XGEN_LAT; keep at least one bit.
  localparam int CNT_W = (XGEN_LAT > 0) ? $clog2(XGEN_LAT + 1) : 1;
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(XGEN_LAT);
  localparam logic [LINK_BITS-1:0] LAST_LINK   = LINK_BITS'(NUM_LINKS);
  localparam logic [LINK_BITS-1:0] FIRST_LINK  = LINK_BITS'(1);

  state_t               state;
  state_t               state_nxt;
  logic [LINK_BITS-1:0] link;
  logic [CNT_W-1:0]     settle_cnt;

  logic start_go;     // sweep launch accepted this cycle
  logic trig_go;      // sin/cos handshake that actually takes effect
  logic capture_go;   // xgen output has settled, grab it
  logic xform_go;     // downstream handshake that actually takes effect
  logic last_link;

  // Abort overrides every handshake in the same cycle, so all "go" strobes
  // are qualified with !abort_in here once.
  assign last_link  = (link == LAST_LINK);
  assign start_go   = (state == IDLE) && start_in && !abort_in;
  assign trig_go    = (state == LOAD) && trig_valid_in && !abort_in;
  assign capture_go = (state == WAIT) && (settle_cnt == SETTLE_LAST) && !abort_in;
  assign xform_go   = (state == OUT) && xform_ready_in && !abort_in;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (abort_in) begin
      // Also covers start_in and abort_in together in IDLE.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start_in)       state_nxt = LOAD;
        LOAD: if (trig_valid_in)  state_nxt = WAIT;
        WAIT: if (settle_cnt == SETTLE_LAST) state_nxt = OUT;
        OUT:  if (xform_ready_in) state_nxt = last_link ? IDLE : LOAD;
        default:                  state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy_out       = 1'b0;
    trig_ready_out = 1'b0;
    case (state)
      IDLE:    busy_out = 1'b0;
      LOAD: begin
        busy_out       = 1'b1;
        trig_ready_out = 1'b1;
      end
      WAIT:    busy_out = 1'b1;
      OUT:     busy_out = 1'b1;
      default: busy_out = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Link and settle counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link       <= '0;
      settle_cnt <= '0;
    end else begin
      if (abort_in) begin
        link <= '0;
      end else if (start_go) begin
        link <= FIRST_LINK;
      end else if (xform_go) begin
        link <= last_link ? '0 : link + LINK_BITS'(1);
      end

      if (trig_go) begin
        settle_cnt <= '0;
      end else if ((state == WAIT) && (settle_cnt != SETTLE_LAST)) begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Broadcast bus to the xgen units. sin/cos hold across IDLE so the xgen
  // outputs stay quiet; only the link select drops back to "none".
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xgen_sinq_out <= '0;
      xgen_cosq_out <= '0;
      xgen_link_out <= '0;
    end else begin
      if (trig_go) begin
        xgen_sinq_out <= sinq_in;
        xgen_cosq_out <= cosq_in;
        xgen_link_out <= link;
      end else if (abort_in || (xform_go && last_link)) begin
        xgen_link_out <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Captured xform and downstream handshake
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xform_out       <= '0;
      xform_link_out  <= '0;
      xform_valid_out <= 1'b0;
    end else begin
      if (capture_go) begin
        xform_out       <= xform_in;
        xform_link_out  <= link;
        xform_valid_out <= 1'b1;
      end else if (abort_in || xform_go) begin
        xform_valid_out <= 1'b0;
      end
    end
  end

  // Registered so the pulse lands in the first IDLE cycle after the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_out <= 1'b0;
    end else begin
      done_out <= xform_go && last_link;
    end
  end

endmodule

// File: tb/tb_xgen_sched.sv
// Scoreboard bench for xgen_sched at XGEN_LAT=0 and XGEN_LAT=3 side by side.
module tb_xgen_sched;

  localparam int W  = 32;
  localparam int NL = 7;
  localparam int LB = 3;
  localparam int XW = 15 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_xf(input string nm, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Stub xgen transfer function: every field depends on sin, cos, link and field index.
  function automatic logic [XW-1:0] xf(input logic [W-1:0] s, input logic [W-1:0] c,
                                       input logic [LB-1:0] l);
    logic [XW-1:0] r;
    for (int k = 0; k < 15; k++)
      r[k*W +: W] = s ^ (c + W'(k) * 32'h0101_0101) ^ {l, 5'(k), 24'h0};
    return r;
  endfunction

  typedef struct {
    logic [LB-1:0] link;
    logic [XW-1:0] xf;
  } exp_t;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int LAT = (g == 0) ? 0 : 3;

    logic          rst_n, start_in, abort_in, busy_out, done_out;
    logic          trig_valid_in, trig_ready_out;
    logic [W-1:0]  sinq_in, cosq_in, xgen_sinq_out, xgen_cosq_out;
    logic [LB-1:0] xgen_link_out, xform_link_out;
    logic [XW-1:0] xform_in, xform_out;
    logic          xform_valid_out, xform_ready_in;

    xgen_sched #(.WIDTH(W), .NUM_LINKS(NL), .LINK_BITS(LB), .XGEN_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_in(start_in), .abort_in(abort_in),
      .busy_out(busy_out), .done_out(done_out),
      .trig_valid_in(trig_valid_in), .trig_ready_out(trig_ready_out),
      .sinq_in(sinq_in), .cosq_in(cosq_in),
      .xgen_sinq_out(xgen_sinq_out), .xgen_cosq_out(xgen_cosq_out),
      .xgen_link_out(xgen_link_out), .xform_in(xform_in),
      .xform_valid_out(xform_valid_out), .xform_ready_in(xform_ready_in),
      .xform_link_out(xform_link_out), .xform_out(xform_out)
    );

    // Stub xgen: combinational at LAT=0, a 3-register pipeline at LAT=3.
    logic [XW-1:0] stage [3];
    always @(posedge clk) begin
      stage[0] <= xf(xgen_sinq_out, xgen_cosq_out, xgen_link_out);
      stage[1] <= stage[0];
      stage[2] <= stage[1];
    end
    assign xform_in = (LAT == 0) ? xf(xgen_sinq_out, xgen_cosq_out, xgen_link_out) : stage[2];

    exp_t exp_q[$];
    int   model_link = 0;
    int   trig_cyc = 0;
    int   n_out = 0;
    int   n_done = 0;
    bit   pat_mode = 1'b1;
    bit   fin = 1'b0;
    bit   nxt;

    function automatic string pfx(input string s);
      return $sformatf("lat%0d_%s", LAT, s);
    endfunction

    // Trig source + reference model: each accepted pair predicts one output
    // (link number in sweep order, stub transform of the pair).
    always @(negedge clk) begin
      nxt = 1'b0;
      if (!rst_n || (busy_out && abort_in)) begin
        exp_q.delete();
      end else begin
        if (!busy_out && start_in && !abort_in) begin
          model_link = 1;
          nxt = 1'b1;
        end
        if (trig_valid_in && trig_ready_out) begin
          exp_q.push_back('{link: LB'(model_link), xf: xf(sinq_in, cosq_in, LB'(model_link))});
          trig_cyc = cyc;
          model_link++;
          nxt = 1'b1;
        end
        if (nxt) begin
          @(posedge clk);
          #1;
          sinq_in = pat_mode ? W'(model_link * 32'h1000) : W'($urandom);
          cosq_in = pat_mode ? 32'h0001_0000 : W'($urandom);
        end
      end
    end

    // Monitor.
    bit            prev_v, prev_hold, exp_done, exp_trdy;
    logic [LB-1:0] prev_link;
    logic [XW-1:0] prev_xf;
    exp_t          e;

    always @(negedge clk) begin
      if (!rst_n) begin
        prev_v = 0; prev_hold = 0; exp_done = 0; exp_trdy = 0;
      end else begin
        check(pfx("done_pulse"), done_out, exp_done);
        if (exp_done) check(pfx("done_idle"), busy_out, 0);
        if (done_out) n_done++;
        exp_done = 0;
        if (exp_trdy) check(pfx("trdy_after_hs"), trig_ready_out, 1);
        exp_trdy = 0;
        if (xform_valid_out) check(pfx("trdy_in_out"), trig_ready_out, 0);
        if (xform_valid_out && !prev_v) check(pfx("latency"), cyc - trig_cyc, 2 + LAT);
        if (prev_hold) begin
          check(pfx("hold_valid"), xform_valid_out, 1);
          check(pfx("hold_link"), xform_link_out, prev_link);
          check_xf(pfx("hold_xform"), xform_out, prev_xf);
        end
        if (xform_valid_out && xform_ready_in && !abort_in) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got output link %0d want none", pfx("unexpected"), xform_link_out);
          end else begin
            e = exp_q.pop_front();
            check(pfx("out_link"), xform_link_out, e.link);
            check_xf(pfx("out_xform"), xform_out, e.xf);
            n_out++;
            if (int'(e.link) == NL) exp_done = 1; else exp_trdy = 1;
          end
        end
        prev_v    = xform_valid_out;
        prev_hold = xform_valid_out && !xform_ready_in && !abort_in;
        prev_link = xform_link_out;
        prev_xf   = xform_out;
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic pulse_start();
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
    endtask

    task automatic wait_done(input string nm);
      bit seen = 0;
      for (int i = 0; i < 400; i++) begin
        tick();
        if (done_out) begin seen = 1; break; end
      end
      check(pfx(nm), seen, 1);
      tick();
    endtask

    task automatic chk_zero(input string nm);
      check(pfx({nm, "_busy"}), busy_out, 0);
      check(pfx({nm, "_done"}), done_out, 0);
      check(pfx({nm, "_trdy"}), trig_ready_out, 0);
      check(pfx({nm, "_xsin"}), xgen_sinq_out, 0);
      check(pfx({nm, "_xcos"}), xgen_cosq_out, 0);
      check(pfx({nm, "_xlink"}), xgen_link_out, 0);
      check(pfx({nm, "_fvld"}), xform_valid_out, 0);
      check(pfx({nm, "_flink"}), xform_link_out, 0);
      check_xf(pfx({nm, "_xform"}), xform_out, '0);
    endtask

    initial begin
      int o0, d0;
      bit seen;
      rst_n = 0; start_in = 0; abort_in = 0; trig_valid_in = 0; xform_ready_in = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("rst");
      rst_n = 1;
      tick();

      // Basic sweep, pattern values, ready and valid held high.
      trig_valid_in = 1; xform_ready_in = 1;
      o0 = n_out; d0 = n_done;
      pulse_start();
      wait_done("basic_done");
      check(pfx("basic_nout"), n_out - o0, 7);
      check(pfx("basic_ndone"), n_done - d0, 1);

      // Backpressure on link 2.
      pat_mode = 0;
      o0 = n_out; d0 = n_done;
      pulse_start();
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        if (xgen_link_out == 2) begin seen = 1; break; end
        tick();
      end
      check(pfx("bp_link2_loaded"), seen, 1);
      xform_ready_in = 0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        if (xform_valid_out) begin seen = 1; break; end
        tick();
      end
      check(pfx("bp_valid_seen"), seen, 1);
      repeat (5) begin
        check(pfx("bp_flink"), xform_link_out, 2);
        check(pfx("bp_trdy"), trig_ready_out, 0);
        tick();
      end
      xform_ready_in = 1;
      wait_done("bp_done");
      check(pfx("bp_nout"), n_out - o0, 7);
      check(pfx("bp_ndone"), n_done - d0, 1);

      // Random valid/ready with a start pulse while busy.
      o0 = n_out; d0 = n_done;
      pulse_start();
      seen = 0;
      for (int i = 0; i < 600; i++) begin
        xform_ready_in = 1'($urandom_range(0, 1));
        trig_valid_in  = 1'($urandom_range(0, 1));
        start_in       = (i == 8);
        tick();
        if (done_out) begin seen = 1; break; end
      end
      start_in = 0; xform_ready_in = 1; trig_valid_in = 1;
      check(pfx("rnd_done"), seen, 1);
      tick();
      check(pfx("rnd_nout"), n_out - o0, 7);
      check(pfx("rnd_ndone"), n_done - d0, 1);
      repeat (3) tick();
      check(pfx("rnd_idle"), busy_out, 0);

      // Abort during WAIT of link 4 with ready high.
      d0 = n_done;
      pulse_start();
      seen = 0;
      for (int i = 0; i < 200; i++) begin
        if (busy_out && xgen_link_out == 4 && !trig_ready_out && !xform_valid_out) begin
          seen = 1; break;
        end
        tick();
      end
      check(pfx("ab_wait_seen"), seen, 1);
      abort_in = 1;
      tick();
      abort_in = 0;
      check(pfx("ab_busy"), busy_out, 0);
      check(pfx("ab_fvld"), xform_valid_out, 0);
      check(pfx("ab_xlink"), xgen_link_out, 0);
      check(pfx("ab_done"), done_out, 0);
      tick();
      check(pfx("ab_ndone"), n_done - d0, 0);
      // start and abort together in IDLE: stays idle.
      start_in = 1; abort_in = 1;
      tick();
      start_in = 0; abort_in = 0;
      check(pfx("ab_start_idle"), busy_out, 0);
      o0 = n_out;
      pulse_start();
      wait_done("ab_restart_done");
      check(pfx("ab_restart_nout"), n_out - o0, 7);

      // Asynchronous reset while holding in OUT.
      xform_ready_in = 0;
      pulse_start();
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        if (xform_valid_out) begin seen = 1; break; end
        tick();
      end
      check(pfx("ar_out_seen"), seen, 1);
      #2 rst_n = 0;
      #1 chk_zero("arst");
      tick();
      rst_n = 1; xform_ready_in = 1;
      tick();

      // Recovery sweep.
      pat_mode = 1;
      o0 = n_out;
      pulse_start();
      wait_done("final_done");
      check(pfx("final_nout"), n_out - o0, 7);
      check(pfx("final_q_empty"), exp_q.size(), 0);
      fin = 1;
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (g_ch[0].fin && g_ch[1].fin) break;
    end
    if (!(g_ch[0].fin && g_ch[1].fin)) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: got fin %0b%0b want 11", g_ch[1].fin, g_ch[0].fin);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
